// File: rtl/da_dct_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : da_dct_row_sequencer
// Description : Bit-serial distributed-arithmetic sequencer for an 8-point
//               transform ROM bank; emits rows 0..7 on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module da_dct_row_sequencer #(
    parameter int W     = 8,
    parameter int ACC_W = W + 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*W-1:0]          x_in,
    output logic [7:0]              rom_s,
    output logic [4:0]              rom_count,
    input  logic signed [10:0]      rom_data,
    output logic signed [ACC_W-1:0] y_out,
    output logic [2:0]              y_idx,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic                    busy
);

    localparam int             C_BW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [C_BW-1:0] C_B_MSB = C_BW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              row_q, row_d;
    logic [C_BW-1:0]         b_q, b_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [8*W-1:0]          x_q, x_d;
    logic signed [ACC_W-1:0] y_out_q, y_out_d;
    logic [2:0]              y_idx_q, y_idx_d;
    logic                    y_valid_q, y_valid_d;
    logic [7:0]              rom_s_q, rom_s_d;
    logic [4:0]              rom_count_q, rom_count_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;

    logic signed [ACC_W-1:0] w_rom_ext;
    logic signed [ACC_W-1:0] w_acc_next;

    assign w_rom_ext  = {{(ACC_W-11){rom_data[10]}}, rom_data};
    // The MSB slice carries negative weight in two's complement.
    assign w_acc_next = (b_q == C_B_MSB) ? (-w_rom_ext) : ((acc_q <<< 1) + w_rom_ext);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        b_d       = b_q;
        acc_d     = acc_q;
        x_d       = x_q;
        y_out_d   = y_out_q;
        y_idx_d   = y_idx_q;
        y_valid_d = y_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = x_in;
                    row_d   = 3'd0;
                    b_d     = C_B_MSB;
                    acc_d   = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                acc_d = w_acc_next;
                if (b_q == '0) begin
                    y_out_d   = w_acc_next;
                    y_idx_d   = row_q;
                    y_valid_d = 1'b1;
                    state_d   = S_OUTPUT;
                end else begin
                    b_d = b_q - 1'b1;
                end
            end
            S_OUTPUT: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    if (row_q != 3'd7) begin
                        row_d   = row_q + 3'd1;
                        b_d     = C_B_MSB;
                        state_d = S_COMPUTE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // ROM address is registered from next-state values so it holds whenever b/row/x hold.
        rom_s_d = '0;
        for (int i = 0; i < 8; i++) begin
            rom_s_d[i] = x_d[i*W + int'(b_d)];
        end
        rom_count_d = {2'b00, row_d};
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            y_out_q     <= '0;
            y_idx_q     <= '0;
            y_valid_q   <= 1'b0;
            rom_s_q     <= '0;
            rom_count_q <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            y_out_q     <= y_out_d;
            y_idx_q     <= y_idx_d;
            y_valid_q   <= y_valid_d;
            rom_s_q     <= rom_s_d;
            rom_count_q <= rom_count_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign rom_s     = rom_s_q;
    assign rom_count = rom_count_q;
    assign y_out     = y_out_q;
    assign y_idx     = y_idx_q;
    assign y_valid   = y_valid_q;

endmodule
`default_nettype wire
